// File: rtl/pulse_to_level.sv
// Turns single-cycle request pulses into fixed high/low level waveforms for an edge-detected
// trigger line; requests arriving mid-waveform are queued in a saturating counter.
module pulse_to_level #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 2,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic              clr_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int unsigned MaxCycles = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0]   HighLoad = CntW'(HIGH_CYCLES);
    localparam logic [CntW-1:0]   LowLoad  = CntW'(LOW_CYCLES);
    localparam logic [CntW-1:0]   CntOne   = CntW'(1);
    localparam logic [PEND_W-1:0] PendOne  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PendMax  = '1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;
    logic              inc, dec, ovf_set, last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        last    = (cnt_q == CntOne);

        case (state_q)
            StIdle: begin
                // A request seen while idle starts directly and never touches the queue.
                if (pulse_in) begin
                    state_d = StHigh;
                    cnt_d   = HighLoad;
                end
            end
            StHigh: begin
                inc = pulse_in;
                if (last) begin
                    state_d = StLow;
                    cnt_d   = LowLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StLow: begin
                if (last) begin
                    if (pend_q != '0) begin
                        dec     = 1'b1;
                        inc     = pulse_in;
                        state_d = StHigh;
                        cnt_d   = HighLoad;
                    end else if (pulse_in) begin
                        state_d = StHigh;
                        cnt_d   = HighLoad;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    inc   = pulse_in;
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PendMax) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PendOne;
        end
        // Set beats clear when both land in the same cycle.
        ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
        level_d = (state_d == StHigh);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Scoreboard bench for pulse_to_level: a behavioural model queues expected outputs per cycle,
// directed cases cover the documented scenarios and a random loopback counts detected edges.
module tb_pulse_to_level;

    localparam int unsigned H  = 4;
    localparam int unsigned L  = 2;
    localparam int unsigned PW = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;

    pulse_to_level #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .PEND_W     (PW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .clr_ovf  (clr_ovf),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        int bsy;
        int pend;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 high, 2 low; rem = cycles left in the phase including this one.
    int m_phase, m_rem, m_pend, m_ovf, m_accepted, m_drops;

    // Loopback edge detector on the generated level.
    logic lvl_prev;
    int   rises;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev <= 1'b0;
            rises    <= 0;
        end else begin
            lvl_prev <= level_out;
            if (level_out && !lvl_prev) rises <= rises + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_pend = 0; m_ovf = 0; m_accepted = 0; m_drops = 0;
    endtask

    task automatic model_update(input logic p, input logic c);
        int ev;
        int start;
        ev = 0;
        start = 0;
        if (m_phase == 0) begin
            if (p) begin
                m_phase = 1; m_rem = H; m_accepted++;
            end
        end else if (m_phase == 2 && m_rem == 1) begin
            if (m_pend > 0) begin
                start = 1;
                m_pend--;
                if (p) begin m_pend++; m_accepted++; end
            end else if (p) begin
                start = 1; m_accepted++;
            end
            if (start != 0) begin m_phase = 1; m_rem = H; end
            else begin m_phase = 0; m_rem = 0; end
        end else begin
            if (p) begin
                if (m_pend == PMAX) begin ev = 1; m_drops++; end
                else begin m_pend++; m_accepted++; end
            end
            if (m_rem == 1) begin
                m_phase = 2; m_rem = L;
            end else begin
                m_rem--;
            end
        end
        if (ev != 0) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic step(input logic p, input logic c);
        exp_t e;
        pulse_in = p;
        clr_ovf  = c;
        model_update(p, c);
        e.lvl  = (m_phase == 1) ? 1 : 0;
        e.bsy  = (m_phase != 0) ? 1 : 0;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        clr_ovf  = 1'b0;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("level_out", int'(level_out), e.lvl);
            check_eq("busy", int'(busy), e.bsy);
            check_eq("pending", int'(pending), e.pend);
            check_eq("ovf", int'(ovf), e.ovf);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && busy; i++) step(1'b0, 1'b0);
        check_eq("drain_idle", int'(busy), 0);
    endtask

    initial begin
        int hi;
        model_reset();
        rst_n = 1'b0;
        #12;
        check_eq("rst_level", int'(level_out), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_pending", int'(pending), 0);
        check_eq("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Single pulse: four high cycles, idle again six edges later.
        step(1'b1, 1'b0);
        hi = int'(level_out);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            hi += int'(level_out);
        end
        check_eq("single_high_len", hi, int'(H));
        check_eq("single_idle", int'(busy), 0);

        // Two pulses one cycle apart.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("two_pend", int'(pending), 1);
        drain();

        // Pending 2 and a pulse on the final low cycle: count holds, next high starts.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_eq("swap_pend", int'(pending), 2);
        check_eq("swap_level", int'(level_out), 1);
        drain();

        // Overflow: five pulses from idle saturate the queue.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_eq("ovf_pend_sat", int'(pending), PMAX);
        check_eq("ovf_set", int'(ovf), 1);
        step(1'b0, 1'b1);
        check_eq("ovf_clr", int'(ovf), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("ovf_set_wins", int'(ovf), 1);
        drain();
        step(1'b0, 1'b1);

        // Asynchronous reset during high with two queued requests.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("pre_rst_pend", int'(pending), 2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_level", int'(level_out), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_pending", int'(pending), 0);
        check_eq("arst_ovf", int'(ovf), 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        hi = int'(level_out);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            hi += int'(level_out);
        end
        check_eq("post_rst_high_len", hi, int'(H));

        // Random bursts looped back through the edge detector.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 99) < 35), logic'($urandom_range(0, 19) == 0));
        end
        drain();
        step(1'b0, 1'b0);
        check_eq("loopback_edges", rises, m_accepted);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
